rx_bram_capture_ctrl: RTL and testbench

- Sequencing controller for the RX 32x1024 sample BRAM.
- Runs the BRAM as a circular pre-trigger capture buffer: it writes incoming 32-bit samples continuously, freezes a window of PRE_TRIG samples before the trigger and DEPTH-PRE_TRIG samples after it, then streams the window out oldest-first.
- Sits between the RX sample pipeline, the BRAM instance and the downstream correlator/host readout.

---
 rtl/rx_bram_capture_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_rx_bram_capture_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_bram_capture_ctrl.sv
// Circular pre-trigger capture sequencer for the RX 32x1024 sample BRAM.
// Writes samples continuously, freezes a window around the trigger, then streams it out oldest-first.
module rx_bram_capture_ctrl #(
  parameter int ADDR_W   = 10,
  parameter int DEPTH    = 1024,
  parameter int PRE_TRIG = 256
) (
  input  logic              crx_clk,
  input  logic              rrx_rst,
  input  logic              erx_en,
  input  logic              istart,
  input  logic              iabort,
  input  logic [31:0]       idata_in,
  input  logic              idata_valid,
  input  logic              itrigger,
  input  logic              iread_req,
  input  logic              iout_ready,
  output logic              ow_enable,
  output logic [ADDR_W-1:0] ow_address,
  output logic [31:0]       owdata,
  output logic              or_enable,
  output logic [ADDR_W-1:0] or_address,
  input  logic [31:0]       ibram_data,
  output logic [31:0]       odata_out,
  output logic              odata_valid,
  output logic              odata_last,
  output logic              odone,
  output logic              obusy,
  output logic [1:0]        ostate
);

  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0]     ZERO_C  = {CW{1'b0}};
  localparam logic [CW-1:0]     ONE_C   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]     PRE_C   = CW'(PRE_TRIG);
  localparam logic [CW-1:0]     POST_C  = CW'(DEPTH - PRE_TRIG);
  localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);
  localparam logic [ADDR_W-1:0] A_ONE_C = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] A_PRE_C = ADDR_W'(PRE_TRIG);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_POST = 3'd2,
    S_DONE = 3'd3,
    S_READ = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     pre_cnt_q, pre_cnt_d;
  logic [CW-1:0]     post_cnt_q, post_cnt_d;
  logic [CW-1:0]     rd_cnt_q, rd_cnt_d;
  logic              pend_q, pend_d;
  logic [31:0]       last_q, last_d;

  logic wr_en_s, rd_issue_s, beat_s, capturing_s;

  always_ff @(posedge crx_clk) begin
    if (rrx_rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= {ADDR_W{1'b0}};
      trig_addr_q <= {ADDR_W{1'b0}};
      rd_ptr_q    <= {ADDR_W{1'b0}};
      pre_cnt_q   <= ZERO_C;
      post_cnt_q  <= ZERO_C;
      rd_cnt_q    <= ZERO_C;
      pend_q      <= 1'b0;
      last_q      <= 32'd0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      trig_addr_q <= trig_addr_d;
      rd_ptr_q    <= rd_ptr_d;
      pre_cnt_q   <= pre_cnt_d;
      post_cnt_q  <= post_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      pend_q      <= pend_d;
      last_q      <= last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    trig_addr_d = trig_addr_q;
    rd_ptr_d    = rd_ptr_q;
    pre_cnt_d   = pre_cnt_q;
    post_cnt_d  = post_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    pend_d      = pend_q;
    last_d      = last_q;

    capturing_s = (state_q == S_PRE) || (state_q == S_POST);
    wr_en_s     = erx_en && idata_valid && capturing_s;
    // Reads in flight count against the window so the last issue never overshoots.
    rd_issue_s  = erx_en && (state_q == S_READ) && iout_ready &&
                  ((rd_cnt_q + (pend_q ? ONE_C : ZERO_C)) < DEPTH_C);
    beat_s      = erx_en && !iabort && (state_q == S_READ) && pend_q;

    if (erx_en) begin
      if (wr_en_s) begin
        wr_ptr_d = wr_ptr_q + A_ONE_C;
      end
      if (rd_issue_s) begin
        rd_ptr_d = rd_ptr_q + A_ONE_C;
      end
      pend_d = rd_issue_s;
      if (beat_s) begin
        rd_cnt_d = rd_cnt_q + ONE_C;
        last_d   = ibram_data;
      end

      if (iabort) begin
        state_d = S_IDLE;
        pend_d  = 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (istart) begin
              state_d   = S_PRE;
              wr_ptr_d  = {ADDR_W{1'b0}};
              pre_cnt_d = ZERO_C;
            end
          end
          S_PRE: begin
            if (itrigger && (pre_cnt_q == PRE_C)) begin
              state_d     = S_POST;
              trig_addr_d = wr_ptr_q;
              post_cnt_d  = idata_valid ? ONE_C : ZERO_C;
              if (idata_valid && (POST_C == ONE_C)) begin
                state_d = S_DONE;
              end
            end else if (idata_valid && (pre_cnt_q != PRE_C)) begin
              pre_cnt_d = pre_cnt_q + ONE_C;
            end
          end
          S_POST: begin
            if (idata_valid) begin
              post_cnt_d = post_cnt_q + ONE_C;
              if ((post_cnt_q + ONE_C) == POST_C) begin
                state_d = S_DONE;
              end
            end
          end
          S_DONE: begin
            if (iread_req) begin
              state_d  = S_READ;
              rd_ptr_d = trig_addr_q - A_PRE_C;
              rd_cnt_d = ZERO_C;
              pend_d   = 1'b0;
            end
          end
          S_READ: begin
            if (beat_s && ((rd_cnt_q + ONE_C) == DEPTH_C)) begin
              state_d = S_IDLE;
            end
          end
          default: begin
            state_d = S_IDLE;
          end
        endcase
      end
    end else begin
      // A beat landing while disabled is dropped; step back so that address is reissued.
      pend_d = 1'b0;
      if (pend_q && (state_q == S_READ)) begin
        rd_ptr_d = rd_ptr_q - A_ONE_C;
      end
    end
  end

  assign ow_enable   = wr_en_s;
  assign ow_address  = wr_ptr_q;
  assign owdata      = capturing_s ? idata_in : 32'd0;
  assign or_enable   = rd_issue_s;
  assign or_address  = rd_ptr_q;
  assign odata_valid = beat_s;
  assign odata_out   = beat_s ? ibram_data : last_q;
  assign odata_last  = beat_s && ((rd_cnt_q + ONE_C) == DEPTH_C);
  assign odone       = (state_q == S_DONE);
  assign obusy       = (state_q != S_IDLE);
  assign ostate      = (state_q == S_READ) ? 2'd3 : state_q[1:0];

endmodule

// File: tb/tb_rx_bram_capture_ctrl.sv
// Randomised bench for rx_bram_capture_ctrl: a BRAM model plus a queue-based
// reference that predicts every output each cycle, and literal pins on window addresses/values.
module tb_rx_bram_capture_ctrl;

  logic        clk = 1'b0;
  logic        rst, en, start, abort, dvalid, trig, rreq, ready;
  logic [31:0] din;
  logic [31:0] bram_q = 32'd0;
  logic        ow_enable, or_enable, odata_valid, odata_last, odone, obusy;
  logic [9:0]  ow_address, or_address;
  logic [31:0] owdata, odata_out;
  logic [1:0]  ostate;

  always #5 clk = ~clk;

  rx_bram_capture_ctrl dut (
    .crx_clk(clk), .rrx_rst(rst), .erx_en(en), .istart(start), .iabort(abort),
    .idata_in(din), .idata_valid(dvalid), .itrigger(trig), .iread_req(rreq),
    .iout_ready(ready), .ow_enable(ow_enable), .ow_address(ow_address),
    .owdata(owdata), .or_enable(or_enable), .or_address(or_address),
    .ibram_data(bram_q), .odata_out(odata_out), .odata_valid(odata_valid),
    .odata_last(odata_last), .odone(odone), .obusy(obusy), .ostate(ostate)
  );

  logic [31:0] bmem [0:1023];
  always @(posedge clk) begin
    if (ow_enable) bmem[ow_address] <= owdata;
    if (or_enable) bram_q <= bmem[or_address];
  end

  // Reference model: phases 0 idle, 1 pre, 2 post, 3 done, 4 read.
  int          m_st = 0, m_wr = 0, m_pre = 0, m_post = 0, m_trig = 0, m_rd = 0, m_beats = 0;
  bit          m_pend = 1'b0;
  logic [31:0] m_last = 32'd0;
  logic [31:0] m_mem [0:1023];
  logic [31:0] exp_q [$];

  int n_vec = 0, n_err = 0;
  int first_raddr, first_val, last_val, beats_seen, last_at, post_writes, reissued, lost_addr;
  bit post_on = 1'b0, reissue_pend = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, want, $time);
    end
  endtask

  task automatic step_model();
    bit inrw, e_wen, e_ren, e_val, e_last;
    logic [31:0] e_wdata, e_dout;
    int wr_now;
    inrw    = (m_st == 1) || (m_st == 2);
    e_wen   = en && dvalid && inrw;
    e_wdata = inrw ? din : 32'd0;
    e_ren   = en && (m_st == 4) && ready && (m_beats + int'(m_pend) < 1024);
    e_val   = en && !abort && (m_st == 4) && m_pend;
    e_dout  = e_val ? ((exp_q.size() > 0) ? exp_q[0] : 32'd0) : m_last;
    e_last  = e_val && (m_beats + 1 == 1024);

    chk("ow_enable", ow_enable, e_wen);
    chk("ow_address", ow_address, m_wr);
    chk("owdata", owdata, e_wdata);
    chk("or_enable", or_enable, e_ren);
    chk("or_address", or_address, m_rd);
    chk("odata_valid", odata_valid, e_val);
    chk("odata_out", odata_out, e_dout);
    chk("odata_last", odata_last, e_last);
    chk("odone", odone, m_st == 3);
    chk("obusy", obusy, m_st != 0);
    chk("ostate", ostate, (m_st == 4) ? 3 : m_st);

    if (or_enable && reissue_pend) begin
      chk("reissue_addr", or_address, lost_addr);
      reissue_pend = 1'b0;
      reissued++;
    end
    if (!rst && !en && m_st == 4 && m_pend) begin
      lost_addr    = (m_rd + 1023) % 1024;
      reissue_pend = 1'b1;
    end
    if (or_enable && first_raddr < 0) first_raddr = or_address;
    if (post_on && ow_enable) post_writes++;
    if (odata_valid) begin
      beats_seen++;
      if (beats_seen == 1) first_val = odata_out;
      last_val = odata_out;
      if (odata_last) last_at = beats_seen;
    end

    wr_now = m_wr;
    if (rst) begin
      m_st = 0; m_wr = 0; m_pre = 0; m_post = 0; m_trig = 0; m_rd = 0; m_beats = 0;
      m_pend = 1'b0; m_last = 32'd0; exp_q.delete();
    end else if (!en) begin
      if (m_st == 4 && m_pend) m_rd = (m_rd + 1023) % 1024;
      m_pend = 1'b0;
    end else begin
      if (e_wen) begin m_mem[m_wr] = din; m_wr = (m_wr + 1) % 1024; end
      if (e_val) begin m_last = exp_q.pop_front(); m_beats++; end
      if (e_ren) m_rd = (m_rd + 1) % 1024;
      m_pend = e_ren;
      if (abort) begin
        m_st = 0; m_pend = 1'b0;
      end else begin
        case (m_st)
          0: if (start) begin m_st = 1; m_wr = 0; m_pre = 0; end
          1: begin
            if (trig && m_pre == 256) begin
              m_trig = wr_now; m_st = 2; m_post = dvalid ? 1 : 0;
            end else if (dvalid && m_pre < 256) m_pre++;
          end
          2: if (dvalid) begin m_post++; if (m_post == 768) m_st = 3; end
          3: if (rreq) begin
            m_st = 4; m_rd = (m_trig + 1024 - 256) % 1024; m_beats = 0; m_pend = 1'b0;
            exp_q.delete();
            for (int i = 0; i < 1024; i++) exp_q.push_back(m_mem[(m_rd + i) % 1024]);
          end
          4: if (e_val && m_beats == 1024) m_st = 0;
          default: m_st = 0;
        endcase
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
    step_model();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(int trig_at, int early_at, bit gaps);
    int s, guard;
    start = 1'b1; cyc(); start = 1'b0;
    s = 0; guard = 0; post_writes = 0; post_on = 1'b0;
    while (m_st != 3 && guard < 5000) begin
      guard++;
      dvalid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      en     = gaps ? ($urandom_range(0, 9) != 0) : 1'b1;
      trig   = 1'b0;
      if (s == trig_at || s == early_at) begin dvalid = 1'b1; en = 1'b1; trig = 1'b1; end
      if (s == trig_at) post_on = 1'b1;
      din = s;
      cyc();
      if (dvalid && en) s++;
    end
    trig = 1'b0; en = 1'b1;
    chk("capture_timeout", guard < 5000, 1'b1);
    dvalid = 1'b1; din = 32'hFFFF;
    repeat (3) cyc();
    dvalid = 1'b0; post_on = 1'b0;
  endtask

  // mode 0: full rate; 1: ready toggles with one dropped beat; 2: random ready and enable
  task automatic readout(int mode);
    int guard, k;
    bit dropped;
    first_raddr = -1; beats_seen = 0; last_at = 0; reissued = 0; dropped = 1'b0;
    ready = 1'b1; rreq = 1'b1; cyc(); rreq = 1'b0;
    guard = 0; k = 0;
    while (m_st == 4 && guard < 6000) begin
      guard++;
      en = 1'b1;
      case (mode)
        1: begin
          ready = (k % 2 == 0);
          if (k >= 40 && m_pend && !dropped) begin en = 1'b0; dropped = 1'b1; end
        end
        2: begin
          ready = 1'($urandom_range(0, 1));
          en    = ($urandom_range(0, 19) != 0);
        end
        default: ready = 1'b1;
      endcase
      cyc();
      k++;
    end
    en = 1'b1; ready = 1'b0;
    chk("readout_timeout", guard < 6000, 1'b1);
    chk("beat_count", beats_seen, 1024);
    chk("last_flag_beat", last_at, 1024);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; start = 1'b0; abort = 1'b0; dvalid = 1'b0;
    trig = 1'b0; rreq = 1'b0; ready = 1'b0; din = 32'd0;
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_obusy", obusy, 1'b0);
    chk("rst_ostate", ostate, 2'd0);
    chk("rst_odata_out", odata_out, 32'd0);

    // Basic window: trigger on sample 300, post writes 300..1067.
    capture(300, -1, 1'b0);
    chk("basic_post_writes", post_writes, 768);
    chk("basic_odone", odone, 1'b1);
    readout(0);
    chk("basic_first_addr", first_raddr, 44);
    chk("basic_first_val", first_val, 44);
    chk("basic_last_val", last_val, 1067);

    // Early trigger at 100 ignored, 400 accepted; read under backpressure with a dropped beat.
    capture(400, 100, 1'b0);
    readout(1);
    chk("early_first_addr", first_raddr, 144);
    chk("early_first_val", first_val, 144);
    chk("early_last_val", last_val, 1167);
    chk("early_reissued", reissued > 0, 1'b1);

    // Wrapped fill: trigger lands at address 10, window starts at 778 and wraps 1023 -> 0.
    capture(1034, -1, 1'b0);
    readout(2);
    chk("wrap_first_addr", first_raddr, 778);
    chk("wrap_first_val", first_val, 778);
    chk("wrap_last_val", last_val, 1801);

    // Sparse valid with occasional enable drops.
    capture(300, -1, 1'b1);
    chk("gaps_post_writes", post_writes, 768);
    readout(0);

    // Abort during POST.
    start = 1'b1; cyc(); start = 1'b0;
    dvalid = 1'b1;
    for (int s = 0; s < 310; s++) begin
      din = s; trig = (s == 300); cyc();
    end
    trig = 1'b0;
    chk("abort_pre_state", ostate, 2'd2);
    abort = 1'b1; din = 32'd999; cyc(); abort = 1'b0;
    chk("abort_obusy", obusy, 1'b0);
    chk("abort_wen", ow_enable, 1'b0);
    chk("abort_ostate", ostate, 2'd0);
    cyc();
    dvalid = 1'b0;

    // Reset in the middle of a readout.
    capture(300, -1, 1'b0);
    ready = 1'b1; rreq = 1'b1; cyc(); rreq = 1'b0;
    repeat (20) cyc();
    rst = 1'b1; cyc(); rst = 1'b0;
    din = 32'h1234; dvalid = 1'b1; ready = 1'b1;
    chk("rrst_wen", ow_enable, 1'b0);
    chk("rrst_waddr", ow_address, 10'd0);
    chk("rrst_wdata", owdata, 32'd0);
    chk("rrst_ren", or_enable, 1'b0);
    chk("rrst_raddr", or_address, 10'd0);
    chk("rrst_dout", odata_out, 32'd0);
    chk("rrst_valid", odata_valid, 1'b0);
    chk("rrst_last", odata_last, 1'b0);
    chk("rrst_done", odone, 1'b0);
    chk("rrst_busy", obusy, 1'b0);
    chk("rrst_state", ostate, 2'd0);
    cyc();
    dvalid = 1'b0; ready = 1'b0;

    // Fresh capture after reset.
    capture(500, -1, 1'b0);
    readout(0);
    chk("fresh_first_addr", first_raddr, 244);
    chk("fresh_first_val", first_val, 244);
    chk("fresh_last_val", last_val, 1267);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
